hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/cpu_pkg.sv | 16 +
 rtl/hz_reg_match.sv | 15 +
 rtl/hazard_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard FSM state encoding, register-file constants
// and the width of the stall statistics counter.
package cpu_pkg;

    localparam int          REG_W       = 4;
    localparam int          STALL_CNT_W = 16;
    localparam logic [3:0]  REG_ZERO    = 4'd0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } hz_state_e;

endpackage

// File: rtl/hz_reg_match.sv
// Producer/consumer register comparison: a live write to a non-zero
// destination that equals a source register the consumer actually reads.
module hz_reg_match
    import cpu_pkg::*;
(
    input  logic             we_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic [REG_W-1:0] src_i,
    input  logic             use_i,
    output logic             match_o
);

    assign match_o = we_i && use_i && (rd_i != REG_ZERO) && (rd_i == src_i);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use and branch interlocks, taken-branch
// flush, HLT drain sequencing and a saturating stall-cycle counter.
module hazard_unit
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_W-1:0]       if_id_rs,
    input  logic [REG_W-1:0]       if_id_rt,
    input  logic                   if_id_uses_rs,
    input  logic                   if_id_uses_rt,
    input  logic                   if_id_is_store,
    input  logic                   if_id_branch,
    input  logic                   if_id_br_reg,
    input  logic                   if_id_halt,
    input  logic                   branch_taken,
    input  logic [REG_W-1:0]       id_ex_rd,
    input  logic                   id_ex_write_reg,
    input  logic                   id_ex_mem_read,
    input  logic                   id_ex_sets_flags,
    input  logic [REG_W-1:0]       ex_mem_rd,
    input  logic                   ex_mem_write_reg,
    input  logic                   mem_wb_halt,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_ex_bubble,
    output logic                   if_id_flush,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    hz_state_e              state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lu_rs, lu_rt, br_ex, br_mem, br_flags;
    logic [1:0] need;

    hz_reg_match u_lu_rs (
        .we_i    (id_ex_write_reg && id_ex_mem_read),
        .rd_i    (id_ex_rd),
        .src_i   (if_id_rs),
        .use_i   (if_id_uses_rs),
        .match_o (lu_rs)
    );

    // A store's data operand is forwarded MEM->MEM, so it never interlocks.
    hz_reg_match u_lu_rt (
        .we_i    (id_ex_write_reg && id_ex_mem_read),
        .rd_i    (id_ex_rd),
        .src_i   (if_id_rt),
        .use_i   (if_id_uses_rt && !if_id_is_store),
        .match_o (lu_rt)
    );

    hz_reg_match u_br_ex (
        .we_i    (id_ex_write_reg),
        .rd_i    (id_ex_rd),
        .src_i   (if_id_rs),
        .use_i   (if_id_br_reg),
        .match_o (br_ex)
    );

    hz_reg_match u_br_mem (
        .we_i    (ex_mem_write_reg),
        .rd_i    (ex_mem_rd),
        .src_i   (if_id_rs),
        .use_i   (if_id_br_reg),
        .match_o (br_mem)
    );

    assign br_flags = if_id_branch && id_ex_sets_flags;
    assign need     = br_ex ? 2'd2 : ((lu_rs || lu_rt || br_flags || br_mem) ? 2'd1 : 2'd0);

    // NOTE: every signal written here gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        halted       = 1'b0;

        unique case (state_q)
            RUN: begin
                if (need != 2'd0) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    cnt_d        = need - 2'd1;
                    if (need != 2'd1) state_d = STALL;
                end else if (if_id_halt) begin
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    state_d     = DRAIN;
                end else if (branch_taken) begin
                    if_id_flush = 1'b1;
                end
            end
            STALL: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                cnt_d        = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = RUN;
            end
            DRAIN: begin
                pc_write    = 1'b0;
                if_id_flush = 1'b1;
                if (mem_wb_halt) state_d = HALTED;
            end
            HALTED: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                halted      = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    assign stall_cnt_d = (id_ex_bubble && (stall_cnt_q != '1))
                         ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;
    assign stall_cnt   = stall_cnt_q;

    // NOTE: state registers use non-blocking assignments so all of them
    // update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with hand-computed expectations.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  if_id_rs, if_id_rt, id_ex_rd, ex_mem_rd;
    logic        if_id_uses_rs, if_id_uses_rt, if_id_is_store;
    logic        if_id_branch, if_id_br_reg, if_id_halt, branch_taken;
    logic        id_ex_write_reg, id_ex_mem_read, id_ex_sets_flags;
    logic        ex_mem_write_reg, mem_wb_halt;
    logic        pc_write, if_id_write, id_ex_bubble, if_id_flush, halted;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_id_rs         (if_id_rs),
        .if_id_rt         (if_id_rt),
        .if_id_uses_rs    (if_id_uses_rs),
        .if_id_uses_rt    (if_id_uses_rt),
        .if_id_is_store   (if_id_is_store),
        .if_id_branch     (if_id_branch),
        .if_id_br_reg     (if_id_br_reg),
        .if_id_halt       (if_id_halt),
        .branch_taken     (branch_taken),
        .id_ex_rd         (id_ex_rd),
        .id_ex_write_reg  (id_ex_write_reg),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_sets_flags (id_ex_sets_flags),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_write_reg (ex_mem_write_reg),
        .mem_wb_halt      (mem_wb_halt),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .id_ex_bubble     (id_ex_bubble),
        .if_id_flush      (if_id_flush),
        .halted           (halted),
        .stall_cnt        (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        if_id_rs = 0; if_id_rt = 0; id_ex_rd = 0; ex_mem_rd = 0;
        if_id_uses_rs = 0; if_id_uses_rt = 0; if_id_is_store = 0;
        if_id_branch = 0; if_id_br_reg = 0; if_id_halt = 0; branch_taken = 0;
        id_ex_write_reg = 0; id_ex_mem_read = 0; id_ex_sets_flags = 0;
        ex_mem_write_reg = 0; mem_wb_halt = 0;
    endtask

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the Mealy outputs: {pc_write, if_id_write, bubble, flush, halted}.
    task automatic check_outs(input string tag, input logic [4:0] exp);
        #1;
        check(tag, {27'd0, pc_write, if_id_write, id_ex_bubble, if_id_flush, halted}, {27'd0, exp});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_load(input logic [3:0] rd);
        id_ex_rd = rd; id_ex_write_reg = 1; id_ex_mem_read = 1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check_outs("reset_outs", 5'b11000);
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Load-use on rs: exactly one bubble.
        set_load(4'd3); if_id_rs = 3; if_id_uses_rs = 1;
        check_outs("lu_rs_stall", 5'b00100);
        step(); clear_inputs();
        check_outs("lu_rs_after", 5'b11000);
        check("lu_rs_cnt", 32'(stall_cnt), 32'd1);

        // Register branch, producer in EX: two bubbles, then RUN.
        id_ex_rd = 5; id_ex_write_reg = 1; if_id_branch = 1; if_id_br_reg = 1; if_id_rs = 5;
        check_outs("br_ex_c1", 5'b00100);
        step();
        check_outs("br_ex_c2", 5'b00100);
        step(); clear_inputs();
        check_outs("br_ex_after", 5'b11000);
        check("br_ex_cnt", 32'(stall_cnt), 32'd3);

        // Store rt is exempt; same rt on a non-store stalls.
        set_load(4'd4); if_id_rt = 4; if_id_uses_rt = 1; if_id_is_store = 1;
        if_id_rs = 1; if_id_uses_rs = 1;
        check_outs("store_rt_exempt", 5'b11000);
        if_id_is_store = 0;
        check_outs("alu_rt_stall", 5'b00100);
        step(); clear_inputs();
        check("alu_rt_cnt", 32'(stall_cnt), 32'd4);

        // R0 producer never interlocks.
        set_load(4'd0); if_id_rs = 0; if_id_uses_rs = 1;
        check_outs("zero_reg", 5'b11000);
        step(); clear_inputs();

        // Register branch, producer in MEM: one bubble.
        ex_mem_rd = 7; ex_mem_write_reg = 1; if_id_br_reg = 1; if_id_branch = 1; if_id_rs = 7;
        check_outs("br_mem_stall", 5'b00100);
        step(); clear_inputs();
        check_outs("br_mem_after", 5'b11000);
        check("br_mem_cnt", 32'(stall_cnt), 32'd5);

        // Taken branch with no hazard: one-cycle flush.
        if_id_branch = 1; branch_taken = 1;
        check_outs("taken_flush", 5'b11010);
        step(); clear_inputs();
        check_outs("taken_after", 5'b11000);

        // Taken branch under a flag hazard: stall wins, flush comes after.
        if_id_branch = 1; branch_taken = 1; id_ex_sets_flags = 1;
        check_outs("taken_flag_stall", 5'b00100);
        step(); id_ex_sets_flags = 0;
        check_outs("taken_flag_flush", 5'b11010);
        step(); clear_inputs();
        check("taken_flag_cnt", 32'(stall_cnt), 32'd6);

        // Halt behind a load-use: stall first, then drain.
        set_load(4'd3); if_id_rs = 3; if_id_uses_rs = 1; if_id_halt = 1;
        check_outs("halt_hz_stall", 5'b00100);
        step(); clear_inputs(); if_id_halt = 1;
        check_outs("halt_enter", 5'b01010);
        step(); clear_inputs();
        check_outs("drain_c1", 5'b01010);
        step();
        check_outs("drain_c2", 5'b01010);
        step(); mem_wb_halt = 1;
        check_outs("drain_c3", 5'b01010);
        step(); clear_inputs(); branch_taken = 1; if_id_branch = 1;
        check_outs("halted_c1", 5'b00001);
        step(); step();
        check_outs("halted_hold", 5'b00001);
        check("halt_cnt", 32'(stall_cnt), 32'd7);
        clear_inputs();

        // Reset pulse mid-DRAIN.
        do_reset();
        if_id_halt = 1;
        step(); clear_inputs();
        check_outs("drain_pre_rst", 5'b01010);
        rst_n = 1'b0;
        check_outs("drain_in_rst", 5'b11000);
        #2; rst_n = 1'b1;
        step();
        check_outs("drain_post_rst", 5'b11000);

        // Reset pulse mid-STALL: no residual bubble.
        id_ex_rd = 5; id_ex_write_reg = 1; if_id_br_reg = 1; if_id_rs = 5;
        step(); clear_inputs();
        check_outs("stall_pre_rst", 5'b00100);
        rst_n = 1'b0;
        check_outs("stall_in_rst", 5'b11000);
        check("stall_rst_cnt", 32'(stall_cnt), 32'd0);
        #2; rst_n = 1'b1;
        step();
        check_outs("stall_post_rst", 5'b11000);
        check("stall_post_rst_cnt", 32'(stall_cnt), 32'd0);

        // Continuous load-use: the counter saturates at FFFF.
        set_load(4'd2); if_id_rs = 2; if_id_uses_rs = 1;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        check("stall_cnt_sat", 32'(stall_cnt), 32'h0000_FFFF);
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
